// File: rtl/mult_div_seq_pkg.sv
// mult_div_seq_pkg: md_op codes, reused ALU op codes and FSM state encodings for mult_div_seq.
// The FIXUP state encoding exists only when MD_SIGNED_EN is defined.
package mult_div_seq_pkg;

  localparam logic [2:0] MD_MULTU = 3'd0;
  localparam logic [2:0] MD_DIVU  = 3'd1;
  localparam logic [2:0] MD_MULT  = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_DONE  = 3'd3
`ifdef MD_SIGNED_EN
    , ST_FIXUP = 3'd4
`endif
  } md_state_e;

endpackage

// File: rtl/mult_div_seq_negate64.sv
// md_negate64: two's-complement negate of a {hi,lo} pair, used by the signed FIXUP step.
// Present only when MD_SIGNED_EN is defined.
`ifdef MD_SIGNED_EN
module md_negate64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = ~i_val + {{(W-1){1'b0}}, 1'b1};

endmodule
`endif

// File: rtl/mult_div_seq.sv
// mult_div_seq: multi-cycle HI/LO unit (MULTU/DIVU, MTHI/MTLO) sequencing the shared EX-stage ALU.
// Define MD_SIGNED_EN to accept MULT/DIV (abs-valued operands plus a sign FIXUP state).
module mult_div_seq
  import mult_div_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         md_op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               kill,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  output md_state_e          o_dbg_state
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is taken only in a cycle where busy=0 and kill=0; busy stays high
  // from the edge after an accepted MULT/DIV through the single done cycle.
  md_state_e        r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc_h, r_acc_l, r_dvsr;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] w_acc_h_nxt, w_acc_l_nxt, w_res_hi, w_res_lo;
  logic [WIDTH-1:0] w_op_a, w_op_b;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_is_mul, w_is_div, w_is_mthi, w_is_mtlo;
  logic             w_accept, w_iter, w_last, w_fits, w_carry, w_commit;

`ifdef MD_SIGNED_EN
  logic               w_is_signed;
  logic               r_fix, r_fix_mul, r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0] w_neg_prod;

  md_negate64 #(.W(2*WIDTH)) u_negate (
    .i_val ({r_acc_h, r_acc_l}),
    .o_val (w_neg_prod)
  );
`endif

  always_comb begin
    w_is_mul  = 1'b0;
    w_is_div  = 1'b0;
    w_is_mthi = 1'b0;
    w_is_mtlo = 1'b0;
`ifdef MD_SIGNED_EN
    w_is_signed = 1'b0;
`endif
    case (md_op)
      MD_MULTU: w_is_mul = 1'b1;
      MD_DIVU:  w_is_div = 1'b1;
      MD_MULT: begin
        w_is_mul = 1'b1;
`ifdef MD_SIGNED_EN
        w_is_signed = 1'b1;
`endif
      end
      MD_DIV: begin
        w_is_div = 1'b1;
`ifdef MD_SIGNED_EN
        w_is_signed = 1'b1;
`endif
      end
      MD_MTHI:  w_is_mthi = 1'b1;
      MD_MTLO:  w_is_mtlo = 1'b1;
      default:  ;
    endcase
  end

`ifdef MD_SIGNED_EN
  assign w_op_a = (w_is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign w_op_b = (w_is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
`else
  assign w_op_a = rs_val;
  assign w_op_b = rt_val;
`endif

  assign w_accept = start && !kill && (r_state == ST_IDLE);
  assign w_iter   = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Multiply keeps the multiplier in acc_l; divide keeps the dividend/quotient there.
  assign w_rem_sh = {r_acc_h, r_acc_l[WIDTH-1]};
  assign w_fits   = w_rem_sh[WIDTH] | !(w_rem_sh[WIDTH-1:0] < r_dvsr);
  assign w_carry  = (alu_out < r_acc_h);

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALUOP_W'(ALU_ADDU);
    w_acc_h_nxt = r_acc_h;
    w_acc_l_nxt = r_acc_l;
    case (r_state)
      ST_MUL: begin
        alu_a       = r_acc_h;
        alu_b       = r_acc_l[0] ? r_dvsr : '0;
        w_acc_h_nxt = {w_carry, alu_out[WIDTH-1:1]};
        w_acc_l_nxt = {alu_out[0], r_acc_l[WIDTH-1:1]};
      end
      ST_DIV: begin
        alu_a       = w_rem_sh[WIDTH-1:0];
        alu_b       = r_dvsr;
        alu_op      = ALUOP_W'(ALU_SUBU);
        w_acc_h_nxt = w_fits ? alu_out : w_rem_sh[WIDTH-1:0];
        w_acc_l_nxt = {r_acc_l[WIDTH-2:0], w_fits};
      end
      default: ;
    endcase
  end

  // HI/LO are loaded on the edge that enters DONE, so they are valid while done is high.
  always_comb begin
    w_res_hi = w_acc_h_nxt;
    w_res_lo = w_acc_l_nxt;
`ifdef MD_SIGNED_EN
    w_commit = !kill && ((w_iter && w_last && !r_fix) || (r_state == ST_FIXUP));
    if (r_state == ST_FIXUP) begin
      if (r_fix_mul) begin
        {w_res_hi, w_res_lo} = r_neg_q ? w_neg_prod : {r_acc_h, r_acc_l};
      end else begin
        w_res_hi = r_neg_r ? -r_acc_h : r_acc_h;
        w_res_lo = r_neg_q ? -r_acc_l : r_acc_l;
      end
    end
`else
    w_commit = !kill && w_iter && w_last;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    if (kill) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_mul)      w_state_nxt = ST_MUL;
          else if (w_accept && w_is_div) w_state_nxt = ST_DIV;
        end
        ST_MUL, ST_DIV: begin
          if (w_last) begin
            w_state_nxt = ST_DONE;
`ifdef MD_SIGNED_EN
            if (r_fix) w_state_nxt = ST_FIXUP;
`endif
          end
        end
`ifdef MD_SIGNED_EN
        ST_FIXUP: w_state_nxt = ST_DONE;
`endif
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc_h <= '0;
      r_acc_l <= '0;
      r_dvsr  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MD_SIGNED_EN
      r_fix     <= 1'b0;
      r_fix_mul <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && (w_is_mul || w_is_div)) begin
        r_cnt   <= '0;
        r_acc_h <= '0;
        r_acc_l <= w_is_mul ? w_op_b : w_op_a;
        r_dvsr  <= w_is_mul ? w_op_a : w_op_b;
`ifdef MD_SIGNED_EN
        r_fix     <= w_is_signed;
        r_fix_mul <= w_is_mul;
        r_neg_q   <= w_is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        r_neg_r   <= w_is_signed && rs_val[WIDTH-1];
`endif
      end else if (w_iter) begin
        r_cnt   <= r_cnt + 1'b1;
        r_acc_h <= w_acc_h_nxt;
        r_acc_l <= w_acc_l_nxt;
      end
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_accept && w_is_mthi) begin
        r_hi <= rs_val;
      end else if (w_accept && w_is_mtlo) begin
        r_lo <= rs_val;
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed HI/LO unit tests with a done-driven scoreboard and a behavioural ALU.
// Add the signed cases by compiling with MD_SIGNED_EN defined for both bench and RTL.
module tb_mult_div_seq;
  import mult_div_seq_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, kill;
  logic [2:0]    md_op;
  logic [W-1:0]  rs_val, rt_val;
  logic          busy, done;
  logic [W-1:0]  hi, lo, alu_a, alu_b, alu_out;
  logic [3:0]    alu_op;
  md_state_e     dbg_state;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m_hi, m_lo;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          st_q[$];

  mult_div_seq #(.WIDTH(W), .ALUOP_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .md_op       (md_op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .kill        (kill),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .o_dbg_state (dbg_state)
  );

  // clock / reset / shared ALU
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (alu_op)
      ALU_ADDU: alu_out = alu_a + alu_b;
      ALU_SUBU: alu_out = alu_a - alu_b;
      default:  alu_out = '0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor: every done pulse pops one expected {hi,lo} and latency
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {63'b0, done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hilo", {hi, lo}, e);
          check("latency", 64'(cyc - st_q.pop_front()), 64'(lat_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", {63'b0, busy}, 64'd0);
  endtask

  task automatic drive_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input int lat);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(negedge clk);
    st_q.push_back(cyc);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    wait_idle(60);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    md_op = MD_MULTU; rs_val = '0; rt_val = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'(ALU_ADDU));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;

    run_md(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33);
    run_md(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, 33);
    run_md(MD_MULTU, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 33);
    run_md(MD_MULTU, 32'h00000000, 32'h12345678, 64'h00000000_00000000, 33);
    run_md(MD_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 33);
    run_md(MD_DIVU,  32'd5,        32'd0,        64'h00000005_FFFFFFFF, 33);
    run_md(MD_DIVU,  32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33);
    run_md(MD_DIVU,  32'h80000000, 32'h10,       64'h00000000_08000000, 33);
    run_md(MD_DIVU,  32'd3,        32'd10,       64'h00000003_00000000, 33);
`ifdef MD_SIGNED_EN
    run_md(MD_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 34);
    run_md(MD_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34);
    run_md(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
    run_md(MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 34);
`else
    run_md(MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33);
    run_md(MD_DIV,   32'd100,      32'd7,        64'h00000002_0000000E, 33);
`endif

    // MTHI / MTLO: update on the next edge, never busy
    drive_start(MD_MTHI, 32'h1234, 32'h0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_lo", 64'(lo), 64'(m_lo));
    check("mthi_busy", {63'b0, busy}, 64'd0);
    m_hi = 32'h1234;
    drive_start(MD_MTLO, 32'hABCD, 32'h0);
    check("mtlo_lo", 64'(lo), 64'hABCD);
    check("mtlo_hi", 64'(hi), 64'(m_hi));
    check("mtlo_busy", {63'b0, busy}, 64'd0);
    m_lo = 32'hABCD;

    // unknown md_op is ignored
    drive_start(3'd6, 32'h5555, 32'h7777);
    check("badop_busy", {63'b0, busy}, 64'd0);
    check("badop_hilo", {hi, lo}, {m_hi, m_lo});

    // kill mid-multiply: no done, HI/LO untouched
    drive_start(MD_MULTU, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    check("prekill_busy", {63'b0, busy}, 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {63'b0, busy}, 64'd0);
    check("kill_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (40) @(negedge clk);
    check("kill_hilo_late", {hi, lo}, {m_hi, m_lo});

    // kill and start in the same cycle: kill wins
    @(negedge clk);
    start = 1'b1; kill = 1'b1; md_op = MD_MULTU; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("killstart_busy", {63'b0, busy}, 64'd0);

    // start while busy is ignored; async reset mid-op clears everything
    drive_start(MD_MULTU, 32'h00010000, 32'h00010000);
    repeat (3) @(negedge clk);
    drive_start(MD_DIVU, 32'd100, 32'd7);
    check("busy_start_state", 64'(dbg_state), 64'(ST_MUL));
    check("busy_start_aluop", 64'(alu_op), 64'(ALU_ADDU));
    check("busy_start_busy", {63'b0, busy}, 64'd1);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_alu", {alu_a, alu_b}, 64'd0);
    check("midrst_aluop", 64'(alu_op), 64'(ALU_ADDU));
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;

    run_md(MD_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
